// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment bus readback logic.
// Segment patterns are ordered {a,b,c,d,e,f,g} and are active-low (0 = lit).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder.
// Maps an active-low {a..g} pattern to its BCD code; the blank pattern maps to
// BCD_BLANK and anything unrecognised maps to BCD_ERR with err raised.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err,
    output logic       blank
);

    // Table lookup; defaults describe the unrecognised-pattern case.
    always_comb begin
        code  = BCD_ERR;
        err   = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_0:     begin code = 4'd0; err = 1'b0; end
            SEG_1:     begin code = 4'd1; err = 1'b0; end
            SEG_2:     begin code = 4'd2; err = 1'b0; end
            SEG_3:     begin code = 4'd3; err = 1'b0; end
            SEG_4:     begin code = 4'd4; err = 1'b0; end
            SEG_5:     begin code = 4'd5; err = 1'b0; end
            SEG_6:     begin code = 4'd6; err = 1'b0; end
            SEG_7:     begin code = 4'd7; err = 1'b0; end
            SEG_8:     begin code = 4'd8; err = 1'b0; end
            SEG_9:     begin code = 4'd9; err = 1'b0; end
            SEG_BLANK: begin code = BCD_BLANK; err = 1'b0; blank = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive monitor for a multiplexed common-anode 7-segment bus.
// A (seg, dig_en) sample must be held for STABLE_CYC consecutive clocks with
// exactly one anode enabled before it is captured into that digit's register;
// each such dwell produces exactly one capture and one upd pulse.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   bcd,
    output logic [NDIG-1:0]     dp_out,
    output logic [NDIG-1:0]     err,
    output logic                upd,
    output logic                frame_done
);

    localparam int               CNT_W   = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYC - 1);

    scan_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        seg_p1;
    logic [NDIG-1:0]   en_p1;
    logic [NDIG-1:0]   seen;

    logic [NDIG-1:0]   sel;
    logic              sample_ok;
    logic              same;
    logic              capture;
    logic [3:0]        dec_code;
    logic              dec_err;
    logic              dec_blank;
    logic [3:0]        cap_code;

    // sel is one-hot exactly when a single anode is driven low.
    assign sel       = ~dig_en;
    assign sample_ok = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
    assign same      = (seg == seg_p1) && (dig_en == en_p1);

    // The capture fires on the edge where the dwell reaches STABLE_CYC samples.
    assign capture   = sample_ok && (state == TRACK) && same && (cnt == CNT_CAP);

    seg7_pattern_decode u_decode (
        .seg   (seg[7:1]),
        .code  (dec_code),
        .err   (dec_err),
        .blank (dec_blank)
    );

    assign cap_code = dec_blank ? BCD_BLANK : dec_code;

    // ---- stage p1: previous-cycle copy of the bus for the stability compare
    // Keep last cycle's bus sample; only ever compared while tracking, so no reset.
    always_ff @(posedge clk) begin
        seg_p1 <= seg;
        en_p1  <= dig_en;
    end

    // Stability FSM: counts identical valid samples, saturating once captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!sample_ok) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= TRACK;
                    cnt   <= CNT_ONE;
                end
                TRACK: begin
                    if (!same) begin
                        cnt <= CNT_ONE;
                    end else if (cnt == CNT_CAP) begin
                        state <= HELD;
                        cnt   <= CNT_MAX;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!same) begin
                        state <= TRACK;
                        cnt   <= CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Digit register file, seen mask and the registered update/frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd        <= {NDIG{BCD_BLANK}};
            dp_out     <= '0;
            err        <= '0;
            seen       <= '0;
            upd        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            upd        <= capture;
            frame_done <= 1'b0;
            if (capture) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (sel[i]) begin
                        bcd[4*i +: 4] <= cap_code;
                        err[i]        <= dec_err;
                        dp_out[i]     <= ~seg[0];
                    end
                end
                if ((seen | sel) == '1) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen | sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized dwells.
// A history-based reference model predicts each capture and pushes it to a
// scoreboard; an independent monitor pops and compares on every upd pulse.
module tb_seg7_scan_decoder;

    localparam int NDIG = 4;
    localparam int S    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        seg;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dp_out;
    logic [NDIG-1:0]   err;
    logic              upd;
    logic              frame_done;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig_en     (dig_en),
        .bcd        (bcd),
        .dp_out     (dp_out),
        .err        (err),
        .upd        (upd),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  err;
        logic        fd;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] hist[$];
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_err, m_seen;
    logic [6:0]  pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int fd_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a capture happens when the newest sample closes a run of
    // exactly S identical, single-digit-enabled samples since the last reset.
    task automatic model_step(input logic r, input logic [7:0] s, input logic [3:0] e);
        logic       ok;
        logic       stable;
        int         n, idx;
        logic [3:0] code;
        logic       perr;
        exp_t       x;
        if (r) begin
            hist.push_back(13'h0);
            m_bcd = 16'hFFFF; m_dp = '0; m_err = '0; m_seen = '0;
        end else begin
            ok = ($countones(~e) == 1);
            hist.push_back({ok, e, s});
            n = hist.size();
            if (ok && n >= S) begin
                stable = 1'b1;
                for (int k = 1; k < S; k++)
                    if (hist[n-1-k] !== hist[n-1]) stable = 1'b0;
                if (n > S && hist[n-1-S] === hist[n-1]) stable = 1'b0;
                if (stable) begin
                    idx = 0;
                    for (int k = 0; k < NDIG; k++) if (!e[k]) idx = k;
                    code = 4'hE; perr = 1'b1;
                    for (int d = 0; d < 10; d++)
                        if (s[7:1] == pat_tab[d]) begin code = 4'(d); perr = 1'b0; end
                    if (s[7:1] == 7'h7F) begin code = 4'hF; perr = 1'b0; end
                    m_bcd[4*idx +: 4] = code;
                    m_err[idx] = perr;
                    m_dp[idx]  = ~s[0];
                    m_seen[idx] = 1'b1;
                    x.fd = (m_seen == 4'hF);
                    if (x.fd) m_seen = '0;
                    x.at = cyc + 1; x.bcd = m_bcd; x.dp = m_dp; x.err = m_err;
                    sb.push_back(x);
                end
            end
        end
        while (hist.size() > S + 1) void'(hist.pop_front());
    endtask

    task automatic drive(input logic r, input logic [7:0] s, input logic [3:0] e);
        @(posedge clk);
        #1;
        rst = r; seg = s; dig_en = e;
        model_step(r, s, e);
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, 8'hFF, 4'hF);
        @(negedge clk);
    endtask

    function automatic logic [3:0] en_of(input int d);
        logic [3:0] v;
        v = 4'hF;
        v[d] = 1'b0;
        return v;
    endfunction

    // Cycle counter used to time-stamp predicted captures.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every upd must match the oldest predicted capture.
    initial forever begin
        exp_t x;
        @(negedge clk);
        if (upd === 1'b1) begin
            upd_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_upd actual=upd required=no_upd (cycle %0d)", cyc);
            end else begin
                x = sb.pop_front();
                check("upd_cycle", cyc, x.at);
                check("bcd", bcd, x.bcd);
                check("dp_out", dp_out, x.dp);
                check("err", err, x.err);
                check("frame_done", frame_done, x.fd);
            end
        end else if (frame_done !== 1'b0) begin
            check("frame_done_without_upd", frame_done, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, f0, len, kind, d;
        logic [7:0] s;
        logic [3:0] e;

        // Reset with random bus contents.
        rst = 1'b1; seg = 8'($urandom); dig_en = 4'($urandom);
        model_step(1'b1, seg, dig_en);
        drive(1'b1, 8'($urandom), 4'($urandom));
        @(negedge clk);
        check("rst_bcd", bcd, 16'hFFFF);
        check("rst_dp", dp_out, 4'h0);
        check("rst_err", err, 4'h0);
        check("rst_upd", upd, 1'b0);
        check("rst_fd", frame_done, 1'b0);

        // Long dwell: one capture only.
        u0 = upd_cnt;
        repeat (14) drive(1'b0, 8'b00100101, 4'b1110);
        flush();
        check("dwell_upd_count", upd_cnt - u0, 1);
        check("dwell_bcd0", bcd[3:0], 4'd2);

        // Glitch: short "5" then stable "6" on digit 1.
        u0 = upd_cnt;
        repeat (3) drive(1'b0, {pat_tab[5], 1'b1}, 4'b1101);
        repeat (4) drive(1'b0, {pat_tab[6], 1'b1}, 4'b1101);
        flush();
        check("glitch_upd_count", upd_cnt - u0, 1);
        check("glitch_bcd1", bcd[7:4], 4'd6);

        // Unrecognised then blank pattern on digit 2.
        repeat (6) drive(1'b0, 8'b11110001, 4'b1011);
        flush();
        check("bad_bcd2", bcd[11:8], 4'hE);
        check("bad_err2", err[2], 1'b1);
        repeat (6) drive(1'b0, 8'hFF, 4'b1011);
        flush();
        check("blank_bcd2", bcd[11:8], 4'hF);
        check("blank_err2", err[2], 1'b0);

        // Full scan 1,2,3,4 with dp on digit 2, starting from a clean seen mask.
        drive(1'b1, 8'hFF, 4'hF);
        f0 = fd_cnt;
        for (int i = 0; i < 4; i++)
            repeat (6) drive(1'b0, {pat_tab[i+1], (i == 2) ? 1'b0 : 1'b1}, en_of(i));
        flush();
        check("scan_bcd", bcd, 16'h4321);
        check("scan_dp", dp_out, 4'b0100);
        check("scan_fd_count", fd_cnt - f0, 1);

        // Two enables low: never a capture.
        u0 = upd_cnt;
        repeat (10) drive(1'b0, 8'($urandom), 4'b1100);
        flush();
        check("multi_en_upd_count", upd_cnt - u0, 0);

        // Reset on the 2nd cycle of a dwell; counting restarts afterwards.
        u0 = upd_cnt;
        drive(1'b0, {pat_tab[7], 1'b1}, 4'b1110);
        drive(1'b1, {pat_tab[7], 1'b1}, 4'b1110);
        repeat (6) drive(1'b0, {pat_tab[7], 1'b1}, 4'b1110);
        flush();
        check("rst_dwell_upd_count", upd_cnt - u0, 1);
        check("rst_dwell_bcd0", bcd[3:0], 4'd7);

        // Randomized dwells, odd enables and occasional resets.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 11);
            d = $urandom_range(0, NDIG - 1);
            if (kind < 10)       s = {pat_tab[kind], 1'($urandom)};
            else if (kind == 10) s = {7'h7F, 1'($urandom)};
            else                 s = 8'($urandom);
            e = ($urandom_range(0, 7) == 0) ? 4'($urandom) : en_of(d);
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, s, e);
        end
        flush();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
